id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Registered, parametrised instruction-decode stage for the MIPS pipeline. It sits between the IF/ID boundary and the register file and EX.
- Extracts opcode, rs, rt, destination, func, shamt and extended immediate. Destination select is 3-way (rt / rd / link register). Immediate extension is mode-selected.
- Results are held in an output pipeline register with valid/ready handshake.
- Detects load-use hazards against the instruction in EX and interlocks; honours flush from branch/exception.

Parameters:
DATA_W, 32, instruction/immediate/PC width (>=32; extension fills to DATA_W)
REG_ADDR_W, 5, register address width
LINK_REG, 31, destination index forced when reg_dst selects link

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept (combinational)
in_inst  in  32  instruction word
in_pc  in  DATA_W  instruction PC
reg_dst  in  2  00 rt, 01 rd, 10 LINK_REG, 11 reserved (treated as rt)
ext_op  in  2  00 sign-extend, 01 zero-extend, 10 upper (imm<<16, low zero), 11 reserved (sign)
ex_is_load  in  1  instruction currently in EX is a load
ex_wreg  in  REG_ADDR_W  destination of instruction in EX
flush  in  1  kill stage contents
out_valid  out  1  decoded bundle valid
out_ready  in  1  downstream accepts
out_opcode  out  6  inst[31:26]
out_rreg_a  out  REG_ADDR_W  inst[25:21]
out_rreg_b  out  REG_ADDR_W  inst[20:16]
out_wreg  out  REG_ADDR_W  selected destination
out_imme  out  DATA_W  extended immediate
out_func  out  6  inst[5:0]
out_shamt  out  5  inst[10:6]
out_pc  out  DATA_W  registered in_pc
hazard  out  1  load-use interlock active (combinational)

Behaviour:
- Reset: out_valid=0; all other outputs 0. Asynchronous assert, synchronous release.
- hazard = in_valid & ex_is_load & (ex_wreg!=0) & (ex_wreg==inst[25:21] | ex_wreg==inst[20:16]).
- in_ready = (~out_valid | out_ready) & ~hazard & ~flush.
- Accept: when in_valid & in_ready, all out_* fields load next edge; out_valid<=1. Latency is 1 cycle.
- Hold: out_valid & ~out_ready. All outputs stay stable; upstream is back-pressured.
- Drain: out_valid & out_ready & ~accept. Next edge out_valid<=0. Data fields keep their last values.
- Hazard: the bubble is inserted by the drain rule. The instruction stays at the input; upstream must hold in_inst/in_pc.
- Flush: priority over everything. Next edge out_valid<=0 and no accept happens. Data fields are don't-care but stay unchanged.
- Simultaneous drain and accept: back-to-back throughput of 1 per cycle.
- Destination rules: reg_dst=10 → LINK_REG regardless of inst. Writes to 0 are not special-cased.
- Extension rules: sign uses inst[15], replicated to DATA_W. Upper uses {inst[15:0],16'b0}, zero-extended to DATA_W.

Optional Feature:
- Macro ID_BRANCH_TARGET_EN.
- Defined: adds outputs out_br_target (DATA_W) = in_pc+4+(sign_ext(imm)<<2) and out_j_target (DATA_W) = {(in_pc+4)[DATA_W-1:28], inst[25:0], 2'b00}. Both are registered with the bundle; reset 0; same hold/flush rules.
- Undefined: ports are absent; no adders.

Decomposition:
- Package id_pkg: reg_dst encodings (REGDST_RT, REGDST_RD, REGDST_LINK) and ext_op encodings (EXT_SIGN, EXT_ZERO, EXT_UPPER). Also opcode field position constants.
- Sub-module id_decode_comb: purely combinational field extraction, destination mux and extension.
- id_stage: handshake, hazard logic and pipeline register only.

Test Plan:
- Reset mid-stream: rst_n low while out_valid=1 → out_valid=0 and all outputs 0 immediately; after release the first accept yields out_valid next edge.
- Basic decode: inst=0x2109FFFC (addi), reg_dst=00, ext_op=00 → out_rreg_a=8, out_wreg=9, out_imme=0xFFFFFFFC; then ext_op=01 → 0x0000FFFC; then ext_op=10 with inst=0x3C011234 → 0x12340000.
- Link destination: reg_dst=10, inst=0x0C000010 → out_wreg=31.
- Load-use: ex_is_load=1, ex_wreg=9, inst rs=9 → hazard=1, in_ready=0, out_valid drops for one cycle. With ex_wreg=0 → no hazard.
- Back-pressure: out_ready=0 for 3 cycles with in_valid=1 → outputs stable and in_ready=0. Then out_ready=1 → one transfer per cycle with no bubble.
- Flush with in_valid=1 and out_valid=1 → next cycle out_valid=0 and no accept; with ID_BRANCH_TARGET_EN, in_pc=0x100 and imm=0x0004 → out_br_target=0x114.

Source files
------------

// File: rtl/id_pkg.sv
// Shared encodings and instruction field positions for the decode stage.
// Optional branch/jump target outputs are enabled by ID_BRANCH_TARGET_EN.
package id_pkg;

    typedef enum logic [1:0] {
        REGDST_RT   = 2'b00,
        REGDST_RD   = 2'b01,
        REGDST_LINK = 2'b10,
        REGDST_RSV  = 2'b11
    } regdst_e;

    typedef enum logic [1:0] {
        EXT_SIGN  = 2'b00,
        EXT_ZERO  = 2'b01,
        EXT_UPPER = 2'b10,
        EXT_RSV   = 2'b11
    } ext_e;

    localparam int OPC_LSB   = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_LSB = 6;
    localparam int FUNC_LSB  = 0;
    localparam int IMM_W     = 16;

endpackage

// File: rtl/id_decode_comb.sv
// Combinational field extraction, destination select and immediate
// extension for one instruction word.
module id_decode_comb
    import id_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int LINK_REG   = 31
) (
    input  logic [31:0]           i_inst,
    input  logic [1:0]            i_reg_dst,
    input  logic [1:0]            i_ext_op,
    output logic [5:0]            o_opcode,
    output logic [REG_ADDR_W-1:0] o_rs,
    output logic [REG_ADDR_W-1:0] o_rt,
    output logic [REG_ADDR_W-1:0] o_wreg,
    output logic [DATA_W-1:0]     o_imme,
    output logic [5:0]            o_func,
    output logic [4:0]            o_shamt
);

    logic [IMM_W-1:0]      w_imm;
    logic [REG_ADDR_W-1:0] w_rd;

    assign w_imm    = i_inst[IMM_W-1:0];
    assign o_opcode = i_inst[OPC_LSB +: 6];
    assign o_rs     = REG_ADDR_W'(i_inst[RS_LSB +: 5]);
    assign o_rt     = REG_ADDR_W'(i_inst[RT_LSB +: 5]);
    assign w_rd     = REG_ADDR_W'(i_inst[RD_LSB +: 5]);
    assign o_func   = i_inst[FUNC_LSB +: 6];
    assign o_shamt  = i_inst[SHAMT_LSB +: 5];

    always_comb begin
        o_wreg = o_rt;
        unique case (regdst_e'(i_reg_dst))
            REGDST_RD:   o_wreg = w_rd;
            REGDST_LINK: o_wreg = REG_ADDR_W'(LINK_REG);
            default:     o_wreg = o_rt;
        endcase
    end

    // Reserved ext_op falls back to sign extension.
    always_comb begin
        o_imme = {DATA_W{w_imm[IMM_W-1]}};
        o_imme[IMM_W-1:0] = w_imm;
        unique case (ext_e'(i_ext_op))
            EXT_ZERO: begin
                o_imme = '0;
                o_imme[IMM_W-1:0] = w_imm;
            end
            EXT_UPPER: begin
                o_imme = '0;
                o_imme[31:16] = w_imm;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// Registered decode stage: handshake, load-use interlock, flush.
// Define ID_BRANCH_TARGET_EN to add registered branch/jump targets.
module id_stage
    import id_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int LINK_REG   = 31
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_inst,
    input  logic [DATA_W-1:0]     in_pc,
    input  logic [1:0]            reg_dst,
    input  logic [1:0]            ext_op,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_wreg,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [5:0]            out_opcode,
    output logic [REG_ADDR_W-1:0] out_rreg_a,
    output logic [REG_ADDR_W-1:0] out_rreg_b,
    output logic [REG_ADDR_W-1:0] out_wreg,
    output logic [DATA_W-1:0]     out_imme,
    output logic [5:0]            out_func,
    output logic [4:0]            out_shamt,
    output logic [DATA_W-1:0]     out_pc,
    output logic                  hazard
`ifdef ID_BRANCH_TARGET_EN
    ,
    output logic [DATA_W-1:0]     out_br_target,
    output logic [DATA_W-1:0]     out_j_target
`endif
);

    logic [5:0]            w_opcode;
    logic [REG_ADDR_W-1:0] w_rs;
    logic [REG_ADDR_W-1:0] w_rt;
    logic [REG_ADDR_W-1:0] w_wreg;
    logic [DATA_W-1:0]     w_imme;
    logic [5:0]            w_func;
    logic [4:0]            w_shamt;
    logic                  w_hazard;
    logic                  w_ready;
    logic                  w_accept;

    logic                  r_valid;
    logic [5:0]            r_opcode;
    logic [REG_ADDR_W-1:0] r_rs;
    logic [REG_ADDR_W-1:0] r_rt;
    logic [REG_ADDR_W-1:0] r_wreg;
    logic [DATA_W-1:0]     r_imme;
    logic [5:0]            r_func;
    logic [4:0]            r_shamt;
    logic [DATA_W-1:0]     r_pc;

    id_decode_comb #(
        .DATA_W    (DATA_W),
        .REG_ADDR_W(REG_ADDR_W),
        .LINK_REG  (LINK_REG)
    ) u_dec (
        .i_inst   (in_inst),
        .i_reg_dst(reg_dst),
        .i_ext_op (ext_op),
        .o_opcode (w_opcode),
        .o_rs     (w_rs),
        .o_rt     (w_rt),
        .o_wreg   (w_wreg),
        .o_imme   (w_imme),
        .o_func   (w_func),
        .o_shamt  (w_shamt)
    );

    assign w_hazard = in_valid & ex_is_load & (ex_wreg != '0)
                    & ((ex_wreg == w_rs) | (ex_wreg == w_rt));
    assign w_ready  = (~r_valid | out_ready) & ~w_hazard & ~flush;
    assign w_accept = in_valid & w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_opcode <= '0;
            r_rs     <= '0;
            r_rt     <= '0;
            r_wreg   <= '0;
            r_imme   <= '0;
            r_func   <= '0;
            r_shamt  <= '0;
            r_pc     <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_opcode <= w_opcode;
            r_rs     <= w_rs;
            r_rt     <= w_rt;
            r_wreg   <= w_wreg;
            r_imme   <= w_imme;
            r_func   <= w_func;
            r_shamt  <= w_shamt;
            r_pc     <= in_pc;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

`ifdef ID_BRANCH_TARGET_EN
    logic [DATA_W-1:0] w_sext;
    logic [DATA_W-1:0] w_pc4;
    logic [DATA_W-1:0] r_br;
    logic [DATA_W-1:0] r_j;

    always_comb begin
        w_sext = {DATA_W{in_inst[15]}};
        w_sext[15:0] = in_inst[15:0];
    end

    assign w_pc4 = in_pc + DATA_W'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br <= '0;
            r_j  <= '0;
        end else if (w_accept) begin
            r_br <= w_pc4 + (w_sext << 2);
            r_j  <= {w_pc4[DATA_W-1:28], in_inst[25:0], 2'b00};
        end
    end

    assign out_br_target = r_br;
    assign out_j_target  = r_j;
`endif

    assign in_ready   = w_ready;
    assign hazard     = w_hazard;
    assign out_valid  = r_valid;
    assign out_opcode = r_opcode;
    assign out_rreg_a = r_rs;
    assign out_rreg_b = r_rt;
    assign out_wreg   = r_wreg;
    assign out_imme   = r_imme;
    assign out_func   = r_func;
    assign out_shamt  = r_shamt;
    assign out_pc     = r_pc;

endmodule

// File: tb/tb_id_stage.sv
// Directed and random checks of id_stage against a transaction-level model.
// Branch target checks are active when ID_BRANCH_TARGET_EN is defined.
module tb_id_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic [1:0]  reg_dst;
    logic [1:0]  ext_op;
    logic        ex_is_load;
    logic [4:0]  ex_wreg;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_opcode;
    logic [4:0]  out_rreg_a;
    logic [4:0]  out_rreg_b;
    logic [4:0]  out_wreg;
    logic [31:0] out_imme;
    logic [5:0]  out_func;
    logic [4:0]  out_shamt;
    logic [31:0] out_pc;
    logic        hazard;
    logic [31:0] out_br_target;
    logic [31:0] out_j_target;

    int errors = 0;
    int checks = 0;

    id_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .in_pc     (in_pc),
        .reg_dst   (reg_dst),
        .ext_op    (ext_op),
        .ex_is_load(ex_is_load),
        .ex_wreg   (ex_wreg),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_opcode(out_opcode),
        .out_rreg_a(out_rreg_a),
        .out_rreg_b(out_rreg_b),
        .out_wreg  (out_wreg),
        .out_imme  (out_imme),
        .out_func  (out_func),
        .out_shamt (out_shamt),
        .out_pc    (out_pc),
`ifdef ID_BRANCH_TARGET_EN
        .out_br_target(out_br_target),
        .out_j_target (out_j_target),
`endif
        .hazard    (hazard)
    );

`ifndef ID_BRANCH_TARGET_EN
    assign out_br_target = '0;
    assign out_j_target  = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        int unsigned op, rs, rt, wr, fn, sh;
        int unsigned imm, pc, br, j;
    } bundle_t;

    bundle_t m;

    function automatic bundle_t decode(int unsigned inst, int unsigned pc,
                                       int unsigned rd_sel, int unsigned ex);
        bundle_t b;
        int signed simm;
        b.v  = 1'b1;
        b.op = inst >> 26;
        b.rs = (inst >> 21) % 32;
        b.rt = (inst >> 16) % 32;
        b.fn = inst % 64;
        b.sh = (inst >> 6) % 32;
        b.wr = (rd_sel == 1) ? (inst >> 11) % 32 : (rd_sel == 2) ? 31 : b.rt;
        simm = inst % 65536;
        if (simm >= 32768) simm = simm - 65536;
        if (ex == 1)      b.imm = inst % 65536;
        else if (ex == 2) b.imm = (inst % 65536) * 65536;
        else              b.imm = int'(simm);
        b.pc = pc;
        b.br = pc + 4 + int'(simm * 4);
        b.j  = ((pc + 4) & 32'hF000_0000) | ((inst % 32'h0400_0000) * 4);
        return b;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".valid"}, 64'(out_valid), 64'(m.v));
        chk({tag, ".op"}, 64'(out_opcode), 64'(m.op));
        chk({tag, ".rs"}, 64'(out_rreg_a), 64'(m.rs));
        chk({tag, ".rt"}, 64'(out_rreg_b), 64'(m.rt));
        chk({tag, ".wreg"}, 64'(out_wreg), 64'(m.wr));
        chk({tag, ".imme"}, 64'(out_imme), 64'(m.imm));
        chk({tag, ".func"}, 64'(out_func), 64'(m.fn));
        chk({tag, ".shamt"}, 64'(out_shamt), 64'(m.sh));
        chk({tag, ".pc"}, 64'(out_pc), 64'(m.pc));
`ifdef ID_BRANCH_TARGET_EN
        chk({tag, ".br"}, 64'(out_br_target), 64'(m.br));
        chk({tag, ".j"}, 64'(out_j_target), 64'(m.j));
`endif
    endtask

    function automatic bundle_t zero_bundle();
        bundle_t b;
        b = '{default: 0};
        return b;
    endfunction

    // One clock: check combinational outputs mid-cycle, advance model, check.
    task automatic cyc(string tag);
        bit hz, rdy;
        int unsigned rs, rt;
        bundle_t nxt;
        @(negedge clk);
        rs  = (in_inst >> 21) % 32;
        rt  = (in_inst >> 16) % 32;
        hz  = in_valid && ex_is_load && ex_wreg != 0
              && (ex_wreg == rs || ex_wreg == rt);
        rdy = (!m.v || out_ready) && !hz && !flush;
        chk({tag, ".hazard"}, 64'(hazard), 64'(hz));
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(rdy));
        nxt = m;
        if (flush)                nxt.v = 1'b0;
        else if (in_valid && rdy) nxt = decode(in_inst, in_pc, reg_dst, ext_op);
        else if (out_ready)       nxt.v = 1'b0;
        @(posedge clk);
        #1;
        m = nxt;
        check_all(tag);
    endtask

    task automatic drive(logic v, logic [31:0] inst, logic [31:0] pc,
                         logic [1:0] rd, logic [1:0] ex);
        in_valid = v;
        in_inst  = inst;
        in_pc    = pc;
        reg_dst  = rd;
        ext_op   = ex;
    endtask

    initial begin
        logic [31:0] save_imme, save_pc;
        logic [4:0]  save_wreg;

        rst_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 2'b00, 2'b00);
        ex_is_load = 1'b0;
        ex_wreg    = '0;
        flush      = 1'b0;
        out_ready  = 1'b1;
        m = zero_bundle();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        drive(1'b1, 32'h2109_FFFC, 32'h0000_0040, 2'b00, 2'b00);
        cyc("addi_sext");
        chk("addi_rs", 64'(out_rreg_a), 64'd8);
        chk("addi_wreg", 64'(out_wreg), 64'd9);
        chk("addi_imm_s", 64'(out_imme), 64'hFFFF_FFFC);
        ext_op = 2'b01;
        cyc("addi_zext");
        chk("addi_imm_z", 64'(out_imme), 64'h0000_FFFC);
        drive(1'b1, 32'h3C01_1234, 32'h0000_0048, 2'b00, 2'b10);
        cyc("lui");
        chk("lui_imm", 64'(out_imme), 64'h1234_0000);
        drive(1'b1, 32'h0C00_0010, 32'h0000_004C, 2'b10, 2'b11);
        cyc("jal");
        chk("jal_wreg", 64'(out_wreg), 64'd31);

        drive(1'b1, 32'h2128_0000, 32'h0000_0050, 2'b00, 2'b00);
        ex_is_load = 1'b1;
        ex_wreg    = 5'd9;
        cyc("loaduse");
        chk("loaduse_bubble", 64'(out_valid), 64'd0);
        ex_is_load = 1'b0;
        cyc("loaduse_go");
        chk("loaduse_go_v", 64'(out_valid), 64'd1);
        drive(1'b1, 32'h2008_0005, 32'h0000_0054, 2'b00, 2'b00);
        ex_is_load = 1'b1;
        ex_wreg    = 5'd0;
        cyc("wreg0");
        chk("wreg0_v", 64'(out_valid), 64'd1);
        ex_is_load = 1'b0;

        drive(1'b1, 32'h0123_4820, 32'h0000_0058, 2'b01, 2'b00);
        cyc("bp_load");
        save_imme = out_imme;
        save_pc   = out_pc;
        save_wreg = out_wreg;
        out_ready = 1'b0;
        drive(1'b1, 32'h8C44_0010, 32'h0000_005C, 2'b00, 2'b00);
        for (int i = 0; i < 3; i++) begin
            cyc("bp_hold");
            chk("bp_stable_pc", 64'(out_pc), 64'(save_pc));
            chk("bp_stable_imm", 64'(out_imme), 64'(save_imme));
            chk("bp_stable_wreg", 64'(out_wreg), 64'(save_wreg));
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc("b2b");
            chk("b2b_pc", 64'(out_pc), 64'(32'h5C + 4 * i));
            in_pc = in_pc + 4;
        end

        drive(1'b1, 32'h1000_0004, 32'h0000_0100, 2'b00, 2'b00);
        cyc("br");
`ifdef ID_BRANCH_TARGET_EN
        chk("br_target", 64'(out_br_target), 64'h114);
`endif
        flush = 1'b1;
        drive(1'b1, 32'h2222_3333, 32'h0000_0200, 2'b00, 2'b00);
        cyc("flush");
        chk("flush_v", 64'(out_valid), 64'd0);
        chk("flush_pc", 64'(out_pc), 64'h100);
        flush = 1'b0;

        cyc("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        m = zero_bundle();
        check_all("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 32'h2109_FFFC, 32'h0000_0300, 2'b00, 2'b00);
        cyc("post_rst");
        chk("post_rst_v", 64'(out_valid), 64'd1);

        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom % 4) != 0;
            in_inst    = $urandom;
            in_pc      = $urandom;
            reg_dst    = 2'($urandom % 4);
            ext_op     = 2'($urandom % 4);
            ex_is_load = ($urandom % 3) == 0;
            ex_wreg    = ($urandom % 2) ? in_inst[25:21] : 5'($urandom % 32);
            flush      = ($urandom % 10) == 0;
            out_ready  = ($urandom % 4) != 0;
            cyc("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
